ram_bist_ctrl: RTL and testbench

Built-in self-test sequencer for the dual-port `mem` macro used by the RAM test designs. On a start pulse it fills every address through the write port with a deterministic address-derived pattern, then reads every address back through the read port and compares the returned words, accounting for the macro's read latency. It reports busy/done, pass/fail, a saturating error count and the first failing address. It sits between a control/status source (JTAG-to-Avalon bridge, probe or top-level pin) and the `mem` instance, and replaces the free-running address counter when the macro is under test.

---
 rtl/ram_bist_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: built-in self-test sequencer for the dual-port mem macro.
// On start it writes an address-derived pattern to every word, reads every
// word back, compares the returned data after RD_LAT clocks and reports
// pass/fail, a saturating error count and the first failing address.
//
// Ports:
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   start_i               one-cycle start request (honoured only when idle)
//   busy_o, done_o        test in progress / one-cycle completion pulse
//   pass_o                last test had no mismatches (valid from done_o)
//   err_cnt_o             mismatching words in the last test, saturating
//   first_err_addr_o      address of the first mismatch
//   wr_addr_o/wr_data_o/wr_en_o   registered write port to mem
//   rd_addr_o/rd_en_o     registered read port to mem
//   rd_data_i             read data, valid RD_LAT clocks after rd_en_o
//
// Build option: define RAM_BIST_STOP_ON_ERR_EN to end the test at the first
// mismatch; by default the whole array is checked and every mismatch counted.
//
// state | meaning
// IDLE  | waiting for start_i, results held
// FILL  | writing pattern, one address per clock
// CHECK | issuing reads, one address per clock
// DRAIN | waiting RD_LAT clocks for in-flight reads
// DONE  | done_o pulse, pass_o valid
module ram_bist_ctrl #(
  parameter int RAM_ADDR_W = 8,
  parameter int CHUNK_W    = 32,
  parameter int CHUNK_CNT  = 4,
  parameter int RD_LAT     = 2,
  parameter int SEED       = 0,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          pass_o,
  output logic [ERR_CNT_W-1:0]          err_cnt_o,
  output logic [RAM_ADDR_W-1:0]         first_err_addr_o,
  output logic [RAM_ADDR_W-1:0]         wr_addr_o,
  output logic [CHUNK_W*CHUNK_CNT-1:0]  wr_data_o,
  output logic                          wr_en_o,
  output logic [RAM_ADDR_W-1:0]         rd_addr_o,
  output logic                          rd_en_o,
  input  logic [CHUNK_W*CHUNK_CNT-1:0]  rd_data_i
);

  localparam int WORD_W = CHUNK_W * CHUNK_CNT;
  localparam logic [RAM_ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ERR_CNT_W-1:0]  ERR_MAX  = '1;

  typedef enum logic [2:0] {IDLE, FILL, CHECK, DRAIN, DONE} state_t;

  state_t                 state;
  logic [2:0]             drain_cnt;
  logic [RD_LAT-1:0]      pipe_vld;
  logic [RAM_ADDR_W-1:0]  pipe_addr [RD_LAT];
  logic                   mismatch;
  logic [ERR_CNT_W-1:0]   err_nxt;

  // Chunk g of word A is (A + SEED + g) mod 2^CHUNK_W.
  function automatic logic [WORD_W-1:0] pattern(input logic [RAM_ADDR_W-1:0] a);
    logic [WORD_W-1:0]  w;
    logic [CHUNK_W-1:0] base;
    base = CHUNK_W'(a) + CHUNK_W'(SEED);
    w = '0;
    for (int g = 0; g < CHUNK_CNT; g++)
      w[g*CHUNK_W +: CHUNK_W] = base + CHUNK_W'(g);
    return w;
  endfunction

  // The oldest pipeline stage lines up with rd_data_i. A whole-word compare
  // is equivalent to "any chunk differs".
  always_comb begin
    mismatch = 1'b0;
    if (pipe_vld[RD_LAT-1] && (state == CHECK || state == DRAIN))
      mismatch = (rd_data_i != pattern(pipe_addr[RD_LAT-1]));
    err_nxt = err_cnt_o;
    if (mismatch && err_cnt_o != ERR_MAX)
      err_nxt = err_cnt_o + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state            <= IDLE;
      drain_cnt        <= '0;
      pipe_vld         <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_addr[i] <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
      wr_addr_o        <= '0;
      wr_data_o        <= '0;
      wr_en_o          <= 1'b0;
      rd_addr_o        <= '0;
      rd_en_o          <= 1'b0;
    end else begin
      pipe_vld[0]  <= rd_en_o;
      pipe_addr[0] <= rd_addr_o;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end

      // err_cnt_o is still zero exactly up to the first mismatch of a test
      err_cnt_o <= err_nxt;
      if (mismatch && err_cnt_o == '0)
        first_err_addr_o <= pipe_addr[RD_LAT-1];

      done_o <= 1'b0;

      case (state)
        IDLE: begin
          if (start_i) begin
            state            <= FILL;
            busy_o           <= 1'b1;
            wr_en_o          <= 1'b1;
            wr_addr_o        <= '0;
            wr_data_o        <= pattern('0);
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
            pass_o           <= 1'b0;
          end
        end
        FILL: begin
          if (wr_addr_o == ADDR_MAX) begin
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            rd_en_o   <= 1'b1;
            rd_addr_o <= '0;
            state     <= CHECK;
          end else begin
            wr_addr_o <= wr_addr_o + 1'b1;
            wr_data_o <= pattern(wr_addr_o + 1'b1);
          end
        end
        CHECK, DRAIN: begin
`ifdef RAM_BIST_STOP_ON_ERR_EN
          if (mismatch) begin
            // abandon remaining reads; in-flight results are discarded
            state     <= DONE;
            done_o    <= 1'b1;
            pass_o    <= 1'b0;
            rd_en_o   <= 1'b0;
            rd_addr_o <= '0;
            pipe_vld  <= '0;
          end else
`endif
          if (state == CHECK) begin
            if (rd_addr_o == ADDR_MAX) begin
              rd_en_o   <= 1'b0;
              rd_addr_o <= '0;
              drain_cnt <= 3'(RD_LAT - 1);
              state     <= DRAIN;
            end else begin
              rd_addr_o <= rd_addr_o + 1'b1;
            end
          end else if (drain_cnt == '0) begin
            // last compare lands on this edge, so judge on err_nxt
            state  <= DONE;
            done_o <= 1'b1;
            pass_o <= (err_nxt == '0);
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
module tb_ram_bist_ctrl;
  localparam int AW = 4;
  localparam int CW = 8;
  localparam int CC = 2;
  localparam int RL = 1;
  localparam int SD = 16;
  localparam int EW = 4;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass, wr_en, rd_en;
  logic [EW-1:0] err_cnt;
  logic [AW-1:0] first_err_addr, wr_addr, rd_addr;
  logic [15:0]   wr_data;
  logic [15:0]   rd_data = '0;

  always #5 clk = ~clk;

  ram_bist_ctrl #(.RAM_ADDR_W(AW), .CHUNK_W(CW), .CHUNK_CNT(CC), .RD_LAT(RL),
                  .SEED(SD), .ERR_CNT_W(EW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err_cnt),
    .first_err_addr_o(first_err_addr),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_en_o(wr_en),
    .rd_addr_o(rd_addr), .rd_en_o(rd_en), .rd_data_i(rd_data)
  );

  // ideal 1-clock-latency memory with selectable read corruption
  logic [15:0] mem [N];
  int fault_mode = 0;

  function automatic logic [15:0] corrupt(input logic [15:0] d, input logic [AW-1:0] a);
    case (fault_mode)
      1: if (a == 4'd5) return d ^ 16'h0100;
      2: return ~d;
      3: if (a == 4'd2) return d ^ 16'h0001;
      default: ;
    endcase
    return d;
  endfunction

  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= corrupt(mem[rd_addr], rd_addr);
  end

  function automatic logic [15:0] exp_word(input int a);
    logic [7:0] b;
    b = 8'(a) + 8'(SD);
    return {b + 8'd1, b};
  endfunction

  typedef struct { int addr; logic [15:0] data; } wr_exp_t;
  typedef struct { int cyc; int pass; int err; int first; } res_t;
  wr_exp_t wq[$];
  int      rdq[$];
  res_t    rq[$];

  int errors = 0, checks = 0;
  int cyc = 0, start_cyc = 0, done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard consumer: writes, reads and completion results
  always @(negedge clk) begin
    wr_exp_t e;
    res_t    r;
    int      ra;
    if (wr_en || rd_en) check("wr_rd_exclusive", {31'b0, wr_en & rd_en}, 32'd0);
    if (wr_en) begin
      if (wq.size() > 0) e = wq.pop_front();
      else begin e.addr = -1; e.data = 'x; end
      check("wr_addr", {28'b0, wr_addr}, e.addr);
      check("wr_data", {16'b0, wr_data}, {16'b0, e.data});
    end
    if (rd_en) begin
      ra = (rdq.size() > 0) ? rdq.pop_front() : -1;
      check("rd_addr", {28'b0, rd_addr}, ra);
    end
    if (done) begin
      done_cnt++;
      if (rq.size() > 0) r = rq.pop_front();
      else r = '{-1, -1, -1, -1};
      check("done_cycle", cyc - start_cyc + 1, r.cyc);
      check("pass", {31'b0, pass}, r.pass);
      check("err_cnt", {28'b0, err_cnt}, r.err);
      check("first_err_addr", {28'b0, first_err_addr}, r.first);
      check("busy_in_done", {31'b0, busy}, 32'd1);
    end
  end

  task automatic push_expect();
    for (int a = 0; a < N; a++) begin
      wq.push_back('{a, exp_word(a)});
      rdq.push_back(a);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check(tag, {11'b0, busy, done, pass, err_cnt, first_err_addr, wr_addr, wr_en, rd_addr, rd_en}, 32'd0);
    check({tag, "_wdata"}, {16'b0, wr_data}, 32'd0);
  endtask

  task automatic run(input int fmode, input int exp_pass, input int exp_err,
                     input int exp_first, input int exp_done, input bit busy_start);
    int d0;
    fault_mode = fmode;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    push_expect();
    rq.push_back('{exp_done, exp_pass, exp_err, exp_first});
    @(posedge clk);
    #1 start = 1'b0;
    start_cyc = cyc;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    if (busy_start) begin
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int i = 0; i < 200 && done_cnt == d0; i++) @(posedge clk);
    check("done_seen", {31'b0, done_cnt != d0}, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("busy_cleared", {31'b0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("pass_hold", {31'b0, pass}, exp_pass);
    check("err_hold", {28'b0, err_cnt}, exp_err);
    check("done_pulses", done_cnt - d0, 32'd1);
    check("wr_queue_drained", wq.size(), 32'd0);
    check("res_queue_drained", rq.size(), 32'd0);
    wq.delete();
    rdq.delete();
    rq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_idle_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(0, 1, 0, 0, 34, 1'b0);   // clean run
    run(1, 0, 1, 5, 34, 1'b0);   // chunk 1 of address 5 corrupted
    run(2, 0, 15, 0, 34, 1'b0);  // every read inverted, count saturates
    run(0, 1, 0, 0, 34, 1'b1);   // start at cycle 10 ignored; results cleared

    // reset while busy at cycle 20, then a normal run
    fault_mode = 0;
    @(negedge clk);
    start = 1'b1;
    push_expect();
    @(posedge clk);
    #1 start = 1'b0;
    start_cyc = cyc;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 check_idle_zero("abort_reset");
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_writes_done", wq.size(), 32'd0);
    wq.delete();
    rdq.delete();
    run(0, 1, 0, 0, 34, 1'b0);

`ifdef RAM_BIST_STOP_ON_ERR_EN
    run(3, 0, 1, 2, 21, 1'b0);   // read of addr 2 at cycle 19, done 2 clocks later
`else
    run(3, 0, 1, 2, 34, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
